memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Two-requester arbiter and sequencer that shares the single data memory between the multicycle CPU's instruction-fetch port and its load/store port. It owns the memory's address, write-data and read/write strobes, runs each accepted request through a fixed accept → access → response sequence, and returns registered read data. Data accesses have priority; a bounded wait counter guarantees fetch forward progress.

## Interface
- ADDR_WIDTH, 32, width of word address on both requester ports and the memory side
- DATA_WIDTH, 32, data word width
- MAX_WAIT, 3, consecutive lost arbitrations after which fetch gets priority (≥1)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; one clock, no other clock domains
- i_req  input  1  fetch request; must hold with i_addr stable until accepted
- i_addr  input  ADDR_WIDTH  fetch word address
- i_ready  output  1  fetch accepted this cycle (i_req && grant to fetch)
- i_rvalid  output  1  one-cycle pulse, i_rdata valid
- i_rdata  output  DATA_WIDTH  fetched word
- d_req  input  1  data request; d_we/d_addr/d_wdata held stable until accepted
- d_we  input  1  1 = write, 0 = read
- d_addr  input  ADDR_WIDTH  data word address
- d_wdata  input  DATA_WIDTH  store data
- d_ready  output  1  data request accepted this cycle
- d_rvalid  output  1  one-cycle pulse; read data valid, or write-complete acknowledge
- d_rdata  output  DATA_WIDTH  loaded word; 0 on write acknowledge
- mem_address  output  ADDR_WIDTH  to memory address
- mem_dataIn  output  DATA_WIDTH  to memory write data
- mem_memRead  output  1  memory read enable
- mem_memWrite  output  1  memory write enable (memory writes on rising clk)
- mem_dataOut  input  DATA_WIDTH  memory combinational read data

## Operation
- FSM states: IDLE, ACCESS, RESP. Arbitration happens only in IDLE and RESP.
- Arbitration: if d_req and (i_req=0 or wait_cnt<MAX_WAIT) → grant data; else if i_req → grant fetch. Grant asserts the matching ready combinationally; acceptance = req && ready. The loser sees ready=0.
- On acceptance: latch owner, we, address and wdata, then go to ACCESS. With no acceptance, IDLE→IDLE and RESP→IDLE.
- ACCESS: drive mem_address/mem_dataIn from latches. Assert mem_memRead for reads or mem_memWrite for writes, never both. At the closing edge, capture mem_dataOut (reads) or 0 (writes) into the owner's rdata register, then go to RESP.
- RESP: pulse the owner's rvalid for exactly one cycle. The other port's rvalid stays 0.
- Outside ACCESS, both memory strobes are 0. mem_address and mem_dataIn hold their last values.
- wait_cnt: increments, saturating at MAX_WAIT, in each arbitration cycle where i_req=1 and data wins. Clears when fetch is accepted. Otherwise holds. It does not change in ACCESS.
- rdata registers hold their value until the next response for that port.

## Timing
- Accept in cycle N → memory access in N+1 → rvalid in N+2.
- Back-to-back accepts are possible in RESP, giving one transaction every 2 cycles.
- A store is visible in memory at the edge ending its ACCESS cycle. A read accepted in the following RESP cycle returns the new value.
- Reset values: state IDLE, wait_cnt 0, all ready/rvalid/strobes 0, rdata 0, mem_address 0, mem_dataIn 0.
- Reset asserted mid-ACCESS drops mem_memWrite immediately, so the write is aborted. The pending response is discarded and no rvalid follows.
- Simultaneous requests with wait_cnt=MAX_WAIT: fetch wins, and data sees d_ready=0.
- A request deasserted before acceptance is simply ignored. No ready is asserted for it.

## Structure
- Shared package mem_arb_pkg holds:
  - the state enum (IDLE, ACCESS, RESP);
  - owner encoding constants OWN_FETCH=0, OWN_DATA=1;
  - the wait-counter width function clog2(MAX_WAIT+1).
- One sub-module is natural: arb_wait_counter, the saturating starvation counter with inc/clear inputs and an at_limit output.

## Test plan
- Memory preloaded with mem[80]=8, mem[81]=44. Data read of addr 80 accepted at cycle N → d_rvalid=1 and d_rdata=8 at N+2. The i_* outputs stay quiet throughout.
- Data write 0x1234 to addr 81, then data read of addr 81 accepted in the RESP cycle → write ack at N+2 with d_rdata=0, then the read returns 0x1234 at N+4.
- i_req and d_req held continuously, with d reads to addr 82 (value 432) and MAX_WAIT=3 → three data grants, then one fetch grant, then repeat. wait_cnt never exceeds 3.
- Fetch only, addr 83 (value −122) → i_rvalid at N+2 with i_rdata=0xFFFFFF86. mem_memWrite stays 0 throughout.
- Reset asserted during the ACCESS cycle of a write of 99 to addr 84 → mem_memWrite falls immediately and mem[84] stays −200. No rvalid, and all outputs return to 0.
- No requests → the FSM stays in IDLE with both memory strobes at 0. A single-cycle d_req that is accepted still completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the fetch/data memory arbiter.
// Pure declarations: no latency, no flow control.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating count of arbitrations fetch has lost in a row; at_limit hands fetch priority.
// Updates on the clock after inc/clr; clr wins over inc.
module arb_wait_counter
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int W = clog2(MAX_WAIT + 1);
  localparam logic [W-1:0] LIMIT = W'(MAX_WAIT);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != LIMIT)) begin
      cnt <= cnt + W'(1);
    end
  end

  assign at_limit = (cnt == LIMIT);

endmodule

// File: rtl/memory_arbiter.sv
// Shares one data memory between fetch and load/store ports; accept -> access -> response,
// 2 cycles accept-to-rvalid; the losing port sees ready=0 and must hold its request.
module memory_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_ready,
  output logic                  i_rvalid,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_ready,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_dataIn,
  output logic                  mem_memRead,
  output logic                  mem_memWrite,
  input  logic [DATA_WIDTH-1:0] mem_dataOut
);

  state_t                state;
  logic                  own_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic arb_cycle;
  logic at_limit;
  logic grant_d;
  logic grant_i;

  // Reset gates arbitration so no ready can escape while the block is held in reset.
  assign arb_cycle = !reset && ((state == IDLE) || (state == RESP));
  assign grant_d   = arb_cycle && d_req && (!i_req || !at_limit);
  assign grant_i   = arb_cycle && i_req && !grant_d;

  assign d_ready = grant_d;
  assign i_ready = grant_i;

  assign mem_address  = addr_q;
  assign mem_dataIn   = wdata_q;
  assign mem_memRead  = (state == ACCESS) && !we_q;
  assign mem_memWrite = (state == ACCESS) && we_q;

  assign i_rvalid = (state == RESP) && (own_q == OWN_FETCH);
  assign d_rvalid = (state == RESP) && (own_q == OWN_DATA);

  arb_wait_counter #(
    .MAX_WAIT(MAX_WAIT)
  ) u_wait (
    .clk     (clk),
    .reset   (reset),
    .inc     (arb_cycle && i_req && grant_d),
    .clr     (grant_i),
    .at_limit(at_limit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      own_q   <= OWN_FETCH;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      case (state)
        IDLE, RESP: begin
          if (grant_d) begin
            own_q   <= OWN_DATA;
            we_q    <= d_we;
            addr_q  <= d_addr;
            wdata_q <= d_wdata;
            state   <= ACCESS;
          end else if (grant_i) begin
            own_q  <= OWN_FETCH;
            we_q   <= 1'b0;
            addr_q <= i_addr;
            state  <= ACCESS;
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          // Stores acknowledge with zero so a stale load value is never mistaken for data.
          if (own_q == OWN_DATA) begin
            d_rdata <= we_q ? '0 : mem_dataOut;
          end else begin
            i_rdata <= mem_dataOut;
          end
          state <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_memory_arbiter;

  localparam int MAXW = 3;

  logic        clk;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ready;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic [31:0] mem_address;
  logic [31:0] mem_dataIn;
  logic        mem_memRead;
  logic        mem_memWrite;
  logic [31:0] mem_dataOut;

  int tests;
  int fails;

  memory_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .MAX_WAIT  (MAXW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_req       (i_req),
    .i_addr      (i_addr),
    .i_ready     (i_ready),
    .i_rvalid    (i_rvalid),
    .i_rdata     (i_rdata),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_ready     (d_ready),
    .d_rvalid    (d_rvalid),
    .d_rdata     (d_rdata),
    .mem_address (mem_address),
    .mem_dataIn  (mem_dataIn),
    .mem_memRead (mem_memRead),
    .mem_memWrite(mem_memWrite),
    .mem_dataOut (mem_dataOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model with a preload port so only one process writes the array.
  logic [31:0] mem [0:255];
  logic        load_en;
  logic [7:0]  load_addr;
  logic [31:0] load_dat;

  always @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_dat;
    else if (mem_memWrite) mem[mem_address[7:0]] <= mem_dataIn;
  end
  assign mem_dataOut = mem[mem_address[7:0]];

  task automatic load(input logic [7:0] a, input logic [31:0] v);
    load_addr = a;
    load_dat  = v;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    load_en = 1'b1;
    for (int a = 80; a < 96; a++) load(8'(a), 32'h1000 + 32'(a));
    load(8'd80, 32'd8);
    load(8'd81, 32'd44);
    load(8'd82, 32'd432);
    load(8'd83, 32'hFFFFFF86);
    load(8'd84, 32'hFFFFFF38);
    load_en = 1'b0;
    #1;
    tests++;
    if ({i_ready, d_ready, i_rvalid, d_rvalid} !== 4'b0) begin
      fails++; $display("FAIL reset_handshake got=%b exp=0000", {i_ready, d_ready, i_rvalid, d_rvalid});
    end
    tests++;
    if ({mem_memRead, mem_memWrite} !== 2'b0) begin
      fails++; $display("FAIL reset_strobes got=%b exp=00", {mem_memRead, mem_memWrite});
    end
    tests++;
    if ({i_rdata, d_rdata} !== 64'h0) begin
      fails++; $display("FAIL reset_rdata got=%h exp=0", {i_rdata, d_rdata});
    end
    tests++;
    if ({mem_address, mem_dataIn} !== 64'h0) begin
      fails++; $display("FAIL reset_membus got=%h exp=0", {mem_address, mem_dataIn});
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_idle();
    for (int c = 0; c < 5; c++) begin
      #1;
      tests++;
      if ({mem_memRead, mem_memWrite, i_ready, d_ready, i_rvalid, d_rvalid} !== 6'b0) begin
        fails++; $display("FAIL idle_quiet cyc=%0d got=%b exp=000000", c,
                          {mem_memRead, mem_memWrite, i_ready, d_ready, i_rvalid, d_rvalid});
      end
      @(negedge clk);
    end
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'd80;
    #1;
    tests++;
    if (d_ready !== 1'b1) begin fails++; $display("FAIL idle_pulse_ready got=%b exp=1", d_ready); end
    @(negedge clk);
    d_req = 1'b0;
    @(negedge clk);
    #1;
    tests++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'd8) begin
      fails++; $display("FAIL idle_pulse_resp got=%b/%0d exp=1/8", d_rvalid, d_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_data_read();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'd80;
    #1;
    tests++;
    if (d_ready !== 1'b1) begin fails++; $display("FAIL dread_ready got=%b exp=1", d_ready); end
    @(negedge clk);
    d_req = 1'b0;
    #1;
    tests++;
    if (mem_memRead !== 1'b1 || mem_memWrite !== 1'b0 || mem_address !== 32'd80) begin
      fails++; $display("FAIL dread_access got=%b%b@%0d exp=10@80", mem_memRead, mem_memWrite, mem_address);
    end
    @(negedge clk);
    #1;
    tests++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'd8) begin
      fails++; $display("FAIL dread_resp got=%b/%0d exp=1/8", d_rvalid, d_rdata);
    end
    tests++;
    if (i_rvalid !== 1'b0 || i_ready !== 1'b0) begin
      fails++; $display("FAIL dread_fetch_quiet got=%b%b exp=00", i_rvalid, i_ready);
    end
    @(negedge clk);
    #1;
    tests++;
    if (d_rvalid !== 1'b0 || d_rdata !== 32'd8) begin
      fails++; $display("FAIL dread_hold got=%b/%0d exp=0/8", d_rvalid, d_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_write_read();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'd81; d_wdata = 32'h1234;
    #1;
    tests++;
    if (d_ready !== 1'b1) begin fails++; $display("FAIL wr_ready got=%b exp=1", d_ready); end
    @(negedge clk);
    d_req = 1'b0;
    #1;
    tests++;
    if (mem_memWrite !== 1'b1 || mem_memRead !== 1'b0 || mem_dataIn !== 32'h1234) begin
      fails++; $display("FAIL wr_access got=%b%b/%h exp=10/1234", mem_memWrite, mem_memRead, mem_dataIn);
    end
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'd81;
    #1;
    tests++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'h0 || d_ready !== 1'b1) begin
      fails++; $display("FAIL wr_ack got=%b/%h rdy=%b exp=1/0 rdy=1", d_rvalid, d_rdata, d_ready);
    end
    @(negedge clk);
    d_req = 1'b0;
    #1;
    tests++;
    if (mem[81] !== 32'h1234 || mem_memRead !== 1'b1) begin
      fails++; $display("FAIL wr_mem got=%h rd=%b exp=1234 rd=1", mem[81], mem_memRead);
    end
    @(negedge clk);
    #1;
    tests++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'h1234) begin
      fails++; $display("FAIL wr_readback got=%b/%h exp=1/1234", d_rvalid, d_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_fairness();
    logic grants [$];
    i_req = 1'b1; i_addr = 32'd83;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'd82;
    for (int c = 0; c < 24; c++) begin
      #1;
      tests++;
      if (i_ready && d_ready) begin fails++; $display("FAIL fair_both_ready cyc=%0d", c); end
      if (d_ready) grants.push_back(1'b1);
      if (i_ready) grants.push_back(1'b0);
      if (d_rvalid) begin
        tests++;
        if (d_rdata !== 32'd432) begin fails++; $display("FAIL fair_drdata got=%0d exp=432", d_rdata); end
      end
      if (i_rvalid) begin
        tests++;
        if (i_rdata !== 32'hFFFFFF86) begin fails++; $display("FAIL fair_irdata got=%h exp=ffffff86", i_rdata); end
      end
      @(negedge clk);
    end
    i_req = 1'b0; d_req = 1'b0;
    tests++;
    if (grants.size() != 12) begin fails++; $display("FAIL fair_count got=%0d exp=12", grants.size()); end
    foreach (grants[k]) begin
      tests++;
      if (grants[k] !== ((k % 4) != 3)) begin
        fails++; $display("FAIL fair_order idx=%0d got_data=%b exp_data=%b", k, grants[k], (k % 4) != 3);
      end
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_fetch();
    i_req = 1'b1; i_addr = 32'd83;
    #1;
    tests++;
    if (i_ready !== 1'b1 || d_ready !== 1'b0) begin
      fails++; $display("FAIL fetch_ready got=%b%b exp=10", i_ready, d_ready);
    end
    @(negedge clk);
    i_req = 1'b0;
    #1;
    tests++;
    if (mem_memRead !== 1'b1 || mem_memWrite !== 1'b0) begin
      fails++; $display("FAIL fetch_access got=%b%b exp=10", mem_memRead, mem_memWrite);
    end
    @(negedge clk);
    #1;
    tests++;
    if (i_rvalid !== 1'b1 || i_rdata !== 32'hFFFFFF86 || d_rvalid !== 1'b0 || mem_memWrite !== 1'b0) begin
      fails++; $display("FAIL fetch_resp got=%b/%h d=%b w=%b exp=1/ffffff86 d=0 w=0",
                        i_rvalid, i_rdata, d_rvalid, mem_memWrite);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_write();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'd84; d_wdata = 32'd99;
    #1;
    tests++;
    if (d_ready !== 1'b1) begin fails++; $display("FAIL rstw_ready got=%b exp=1", d_ready); end
    @(negedge clk);
    d_req = 1'b0;
    #1;
    tests++;
    if (mem_memWrite !== 1'b1) begin fails++; $display("FAIL rstw_strobe got=%b exp=1", mem_memWrite); end
    reset = 1'b1;
    #1;
    tests++;
    if (mem_memWrite !== 1'b0 || mem_address !== 32'h0 || mem_dataIn !== 32'h0) begin
      fails++; $display("FAIL rstw_abort got=%b/%h/%h exp=0/0/0", mem_memWrite, mem_address, mem_dataIn);
    end
    @(posedge clk);
    #1;
    tests++;
    if (mem[84] !== 32'hFFFFFF38) begin fails++; $display("FAIL rstw_mem got=%h exp=ffffff38", mem[84]); end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests++;
      if ({i_rvalid, d_rvalid, mem_memRead, mem_memWrite, i_ready, d_ready} !== 6'b0 ||
          {i_rdata, d_rdata} !== 64'h0) begin
        fails++; $display("FAIL rstw_quiet cyc=%0d got=%b rdata=%h exp=0",
                          c, {i_rvalid, d_rvalid, mem_memRead, mem_memWrite, i_ready, d_ready}, {i_rdata, d_rdata});
      end
      @(negedge clk);
    end
  endtask

  // Reference: a transaction occupies the memory the cycle after acceptance and
  // answers the cycle after that; arbitration only when no access is in flight.
  task automatic test_random();
    logic [31:0] ref_mem [0:255];
    logic        busy, resp_vld, resp_data_own;
    logic        cur_data, cur_we;
    logic [31:0] cur_addr, cur_wd;
    logic [31:0] ref_rd_i, ref_rd_d;
    int          losses;
    logic        i_pend, d_pend, exp_d_rdy, exp_i_rdy;
    localparam int N = 1500;

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 256; a++) ref_mem[a] = mem[a];
    busy = 1'b0; resp_vld = 1'b0; resp_data_own = 1'b0;
    cur_data = 1'b0; cur_we = 1'b0; cur_addr = '0; cur_wd = '0;
    ref_rd_i = '0; ref_rd_d = '0; losses = 0;
    i_pend = 1'b0; d_pend = 1'b0;

    for (int cyc = 0; cyc < N; cyc++) begin
      if (i_pend && $urandom_range(7) == 0) i_pend = 1'b0;
      if (d_pend && $urandom_range(7) == 0) d_pend = 1'b0;
      if (!i_pend && $urandom_range(2) == 0) begin
        i_pend = 1'b1; i_addr = 32'd80 + 32'($urandom_range(15));
      end
      if (!d_pend && $urandom_range(2) == 0) begin
        d_pend = 1'b1; d_we = 1'($urandom_range(1));
        d_addr = 32'd80 + 32'($urandom_range(15)); d_wdata = $urandom;
      end
      if (cyc >= N - 4) begin i_pend = 1'b0; d_pend = 1'b0; end
      i_req = i_pend;
      d_req = d_pend;
      #1;

      exp_d_rdy = !busy && d_req && (!i_req || losses < MAXW);
      exp_i_rdy = !busy && i_req && !exp_d_rdy;

      tests++;
      if (d_ready !== exp_d_rdy || i_ready !== exp_i_rdy) begin
        fails++; $display("FAIL rnd_ready cyc=%0d got=d%b i%b exp=d%b i%b", cyc, d_ready, i_ready, exp_d_rdy, exp_i_rdy);
      end
      tests++;
      if (d_rvalid !== (resp_vld && resp_data_own) || i_rvalid !== (resp_vld && !resp_data_own)) begin
        fails++; $display("FAIL rnd_rvalid cyc=%0d got=d%b i%b exp=d%b i%b", cyc, d_rvalid, i_rvalid,
                          resp_vld && resp_data_own, resp_vld && !resp_data_own);
      end
      tests++;
      if (d_rdata !== ref_rd_d || i_rdata !== ref_rd_i) begin
        fails++; $display("FAIL rnd_rdata cyc=%0d got=d%h i%h exp=d%h i%h", cyc, d_rdata, i_rdata, ref_rd_d, ref_rd_i);
      end
      tests++;
      if (mem_memWrite !== (busy && cur_we) || mem_memRead !== (busy && !cur_we) ||
          (busy && mem_address !== cur_addr)) begin
        fails++; $display("FAIL rnd_mem cyc=%0d got=w%b r%b a%0d exp=w%b r%b a%0d", cyc, mem_memWrite,
                          mem_memRead, mem_address, busy && cur_we, busy && !cur_we, cur_addr);
      end

      resp_vld = busy;
      resp_data_own = cur_data;
      if (busy) begin
        if (cur_we) ref_mem[cur_addr[7:0]] = cur_wd;
        if (cur_data) ref_rd_d = cur_we ? 32'h0 : ref_mem[cur_addr[7:0]];
        else ref_rd_i = ref_mem[cur_addr[7:0]];
        busy = 1'b0;
      end else if (exp_d_rdy) begin
        busy = 1'b1; cur_data = 1'b1; cur_we = d_we; cur_addr = d_addr; cur_wd = d_wdata;
        d_pend = 1'b0;
        if (i_req && losses < MAXW) losses++;
      end else if (exp_i_rdy) begin
        busy = 1'b1; cur_data = 1'b0; cur_we = 1'b0; cur_addr = i_addr;
        i_pend = 1'b0;
        losses = 0;
      end
      @(negedge clk);
    end
    i_req = 1'b0; d_req = 1'b0;
    for (int a = 80; a < 96; a++) begin
      tests++;
      if (mem[a] !== ref_mem[a]) begin
        fails++; $display("FAIL rnd_memfinal addr=%0d got=%h exp=%h", a, mem[a], ref_mem[a]);
      end
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    reset = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    load_en = 1'b0; load_addr = '0; load_dat = '0;
    @(negedge clk);
    test_reset();
    test_idle();
    test_data_read();
    test_write_read();
    test_fairness();
    test_fetch();
    test_reset_mid_write();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
